alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of alu_32.
- Decodes a MIPS instruction word into the 4-bit ALU control code.
- Selects the t operand from the register value or the extended immediate.
- Registers s, t and control for the ALU, behind a one-entry valid/ready pipeline register with flush and an illegal-instruction counter.

Parameters:
ILLEGAL_CTRL, 4'h0, control code driven for undecodable instructions
CNT_WIDTH, 8, width of the saturating illegal-instruction counter

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents an instruction this cycle
in_ready  output  1  stage can accept this cycle
instr  input  32  instruction word
rs_val  input  32  register-file value of rs
rt_val  input  32  register-file value of rt
flush  input  1  discard held and incoming instruction
out_valid  output  1  s/t/control/dest hold a valid operation
out_ready  input  1  downstream consumes this cycle
s  output  32  ALU operand s
t  output  32  ALU operand t
control  output  4  ALU control code
dest_reg  output  5  writeback register index
reg_write  output  1  result is to be written back
illegal  output  1  held instruction was undecodable
illegal_count  output  CNT_WIDTH  saturating count of accepted illegal instructions

Behaviour:
- Reset (clk edge with reset=1) clears out_valid, s, t, control, dest_reg, reg_write, illegal and illegal_count to 0. Reset overrides flush and all transfers.
- in_ready = !out_valid || out_ready. It is combinational and has no dependence on in_valid.
- Accept when in_valid && in_ready && !flush. The decoded fields are registered on that edge and out_valid=1 next cycle. Latency is 1 cycle.
- Drain when out_valid && out_ready without a new accept: out_valid goes to 0. Simultaneous drain and accept is full throughput; the new entry replaces the old one.
- Stall when out_valid && !out_ready: s, t, control, dest_reg, reg_write and illegal stay bit-stable.
- Flush=1 clears out_valid on the next edge and blocks acceptance that cycle. Data registers may hold stale values.
- Decode, opcode=instr[31:26], funct=instr[5:0], imm=instr[15:0]:
  - op 0x00, funct 0x20/0x21 -> 4'h2; 0x22/0x23 -> 4'h6; 0x24 -> 4'h0; 0x25 -> 4'h1; 0x27 -> 4'hC; 0x2A -> 4'h7. For these: t=rt_val, dest=instr[15:11], reg_write=1.
  - 0x08/0x09 -> 4'h2, sign-extended imm.
  - 0x0A -> 4'h7, sign-extended imm.
  - 0x0C -> 4'h0, zero-extended imm.
  - 0x0D -> 4'h1, zero-extended imm.
  - For these five immediate opcodes: dest=instr[20:16], reg_write=1.
  - 0x23 (lw) -> 4'h2, sign-extended imm, dest=instr[20:16], reg_write=1.
  - 0x2B (sw) -> 4'h2, sign-extended imm, reg_write=0.
  - 0x04 (beq) -> 4'h6, t=rt_val, reg_write=0.
  - Any other opcode/funct -> control=ILLEGAL_CTRL, t=rt_val, dest=0, reg_write=0, illegal=1.
- s = rs_val for every instruction.
- If the decoded dest is 0, reg_write is forced to 0.
- illegal_count increments on each accepted illegal instruction. It saturates at all-ones and never wraps. Flushed or unaccepted instructions are not counted.
- Sign extension is {{16{imm[15]}},imm]; zero extension is {16'b0,imm}.

Test Plan:
- Reset asserted mid-stall with out_valid=1 -> next cycle out_valid=0, all outputs 0, illegal_count=0, in_ready=1.
- add $3,$1,$2 (instr 32'h00221820) with rs_val=5, rt_val=7, out_ready=1 -> one cycle later out_valid=1, s=5, t=7, control=4'h2, dest_reg=3, reg_write=1.
- addi $4,$0,-1 (32'h2004FFFF) -> t=32'hFFFFFFFF, control=4'h2. Then ori $4,$0,16'hFFFF (32'h3404FFFF) -> t=32'h0000FFFF, control=4'h1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Raise out_ready -> the queued instruction appears the following cycle with no loss or duplication.
- flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, the incoming instruction is dropped and illegal_count is unchanged.
- Feed 260 accepted instrs with opcode 0x3F and CNT_WIDTH=8 -> illegal=1, control=ILLEGAL_CTRL, reg_write=0, illegal_count saturates at 255.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding alu_32: decodes a MIPS word into ALU control,
// selects the t operand and holds the result in a one-entry valid/ready register.
module alu_issue_stage #(
  parameter logic [3:0] ILLEGAL_CTRL = 4'h0,
  parameter int         CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [31:0]          rs_val,
  input  logic [31:0]          rt_val,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          s,
  output logic [31:0]          t,
  output logic [3:0]           control,
  output logic [4:0]           dest_reg,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  logic                 out_valid_q;
  logic [31:0]          s_q, t_q;
  logic [3:0]           control_q;
  logic [4:0]           dest_q;
  logic                 reg_write_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, imm_zext;
  logic [3:0]  control_d;
  logic [31:0] t_d;
  logic [4:0]  dest_d;
  logic        wr_dec, reg_write_d, illegal_d;
  logic        accept;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'b0, instr[15:0]};

  always_comb begin
    control_d = ILLEGAL_CTRL;
    t_d       = rt_val;
    dest_d    = 5'd0;
    wr_dec    = 1'b0;
    illegal_d = 1'b1;
    case (opcode)
      6'h00: begin
        control_d = ILLEGAL_CTRL;
        dest_d    = instr[15:11];
        wr_dec    = 1'b1;
        illegal_d = 1'b0;
        case (funct)
          6'h20, 6'h21: control_d = 4'h2;
          6'h22, 6'h23: control_d = 4'h6;
          6'h24:        control_d = 4'h0;
          6'h25:        control_d = 4'h1;
          6'h27:        control_d = 4'hC;
          6'h2A:        control_d = 4'h7;
          default: begin
            dest_d    = 5'd0;
            wr_dec    = 1'b0;
            illegal_d = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h23: begin
        control_d = 4'h2; t_d = imm_sext; dest_d = instr[20:16];
        wr_dec = 1'b1; illegal_d = 1'b0;
      end
      6'h0A: begin
        control_d = 4'h7; t_d = imm_sext; dest_d = instr[20:16];
        wr_dec = 1'b1; illegal_d = 1'b0;
      end
      6'h0C: begin
        control_d = 4'h0; t_d = imm_zext; dest_d = instr[20:16];
        wr_dec = 1'b1; illegal_d = 1'b0;
      end
      6'h0D: begin
        control_d = 4'h1; t_d = imm_zext; dest_d = instr[20:16];
        wr_dec = 1'b1; illegal_d = 1'b0;
      end
      6'h2B: begin
        control_d = 4'h2; t_d = imm_sext; illegal_d = 1'b0;
      end
      6'h04: begin
        control_d = 4'h6; illegal_d = 1'b0;
      end
      default: ;
    endcase
    // $0 is hardwired, so a write to it is never performed
    reg_write_d = wr_dec && (dest_d != 5'd0);
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      t_q         <= '0;
      control_q   <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        s_q         <= rs_val;
        t_q         <= t_d;
        control_q   <= control_d;
        dest_q      <= dest_d;
        reg_write_q <= reg_write_d;
        illegal_q   <= illegal_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && illegal_d && (count_q != '1))
        count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign out_valid     = out_valid_q;
  assign s             = s_q;
  assign t             = t_q;
  assign control       = control_q;
  assign dest_reg      = dest_q;
  assign reg_write     = reg_write_q;
  assign illegal       = illegal_q;
  assign illegal_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps plus random traffic against a
// transaction-level model of the decode table and the one-entry buffer.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, rs_val, rt_val, s, t;
  logic [3:0]  control;
  logic [4:0]  dest_reg;
  logic        reg_write, illegal;
  logic [7:0]  illegal_count;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.ILLEGAL_CTRL(4'h0), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .t(t),
    .control(control), .dest_reg(dest_reg), .reg_write(reg_write),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ctrl;
    int unsigned tval;
    int unsigned dest;
    bit          dest_known;
    bit          wr;
    bit          ill;
  } op_t;

  bit          m_valid;
  int unsigned m_s;
  op_t         m_op;
  int          m_cnt;

  function automatic op_t decode(input logic [31:0] w, input logic [31:0] rt);
    op_t o;
    int unsigned op, fn, imm, rd, rtf;
    int          simm;
    op   = w >> 26;
    fn   = w & 32'h3F;
    imm  = w & 32'hFFFF;
    rd   = (w >> 11) & 32'h1F;
    rtf  = (w >> 16) & 32'h1F;
    simm = (imm >= 32768) ? int'(imm) - 65536 : int'(imm);
    o = '{ctrl: 0, tval: rt, dest: 0, dest_known: 1, wr: 0, ill: 1};
    if (op == 0) begin
      o.ill = 0; o.dest = rd; o.wr = 1;
      if (fn == 32 || fn == 33)      o.ctrl = 2;
      else if (fn == 34 || fn == 35) o.ctrl = 6;
      else if (fn == 36)             o.ctrl = 0;
      else if (fn == 37)             o.ctrl = 1;
      else if (fn == 39)             o.ctrl = 12;
      else if (fn == 42)             o.ctrl = 7;
      else begin o.ill = 1; o.dest = 0; o.wr = 0; end
    end else if (op == 8 || op == 9 || op == 10 || op == 35) begin
      o = '{ctrl: (op == 10) ? 7 : 2, tval: int'(simm), dest: rtf, dest_known: 1, wr: 1, ill: 0};
    end else if (op == 12 || op == 13) begin
      o = '{ctrl: op - 12, tval: imm, dest: rtf, dest_known: 1, wr: 1, ill: 0};
    end else if (op == 43) begin
      o = '{ctrl: 2, tval: int'(simm), dest: 0, dest_known: 0, wr: 0, ill: 0};
    end else if (op == 4) begin
      o = '{ctrl: 6, tval: rt, dest: 0, dest_known: 0, wr: 0, ill: 0};
    end
    if (o.dest == 0) o.wr = 0;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_valid = 0; m_s = 0; m_cnt = 0;
      m_op = '{ctrl: 0, tval: 0, dest: 0, dest_known: 1, wr: 0, ill: 0};
    end else if (flush) begin
      m_valid = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1;
      m_s     = rs_val;
      m_op    = decode(instr, rt_val);
      if (m_op.ill && m_cnt < 255) m_cnt++;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
    if (m_valid) begin
      chk("s", s, m_s);
      chk("t", t, m_op.tval);
      chk("control", 32'(control), m_op.ctrl);
      chk("reg_write", 32'(reg_write), 32'(m_op.wr));
      chk("illegal", 32'(illegal), 32'(m_op.ill));
      if (m_op.dest_known) chk("dest_reg", 32'(dest_reg), m_op.dest);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h00};
    logic [5:0] fns [9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 9)];
    if (w[31:26] == 6'h00 && $urandom_range(0, 4) != 0) w[5:0] = fns[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    reset = 1; in_valid = 0; instr = 0; rs_val = 0; rt_val = 0; flush = 0; out_ready = 0;
    cycle(); cycle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_s", s, 0);
    chk("rst_control", 32'(control), 0);
    chk("rst_count", 32'(illegal_count), 0);

    reset = 0; in_valid = 1; instr = 32'h00221820; rs_val = 5; rt_val = 7; out_ready = 1;
    cycle();
    chk("add_s", s, 5);
    chk("add_t", t, 7);
    chk("add_ctrl", 32'(control), 2);
    chk("add_dest", 32'(dest_reg), 3);
    chk("add_wr", 32'(reg_write), 1);

    instr = 32'h2004FFFF; rs_val = 0; rt_val = 32'h1234;
    cycle();
    chk("addi_t", t, 32'hFFFFFFFF);
    chk("addi_ctrl", 32'(control), 2);
    instr = 32'h3404FFFF;
    cycle();
    chk("ori_t", t, 32'h0000FFFF);
    chk("ori_ctrl", 32'(control), 1);

    out_ready = 0; instr = 32'h00432022; rs_val = 32'hA; rt_val = 32'h3;
    repeat (3) begin
      cycle();
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_t", t, 32'h0000FFFF);
    end
    out_ready = 1;
    cycle();
    chk("queued_ctrl", 32'(control), 6);
    chk("queued_dest", 32'(dest_reg), 4);
    in_valid = 0;
    cycle();
    chk("drained", 32'(out_valid), 0);
    cycle();

    in_valid = 1; instr = 32'hFC000000;
    cycle();
    chk("ill_count1", 32'(illegal_count), 1);
    in_valid = 0; out_ready = 0;
    cycle();
    reset = 1;
    cycle();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_illegal", 32'(illegal), 0);
    chk("midrst_count", 32'(illegal_count), 0);
    chk("midrst_ready", 32'(in_ready), 1);

    reset = 0; in_valid = 1; instr = 32'h00221820; out_ready = 0;
    cycle();
    flush = 1; instr = 32'hFC000000;
    cycle();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_count", 32'(illegal_count), 0);
    flush = 0; in_valid = 0;
    cycle();
    chk("flush_dropped", 32'(out_valid), 0);

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = rand_instr();
      rs_val    = $urandom;
      rt_val    = $urandom;
      cycle();
    end

    reset = 1; flush = 0;
    cycle();
    reset = 0; in_valid = 1; out_ready = 1;
    for (int i = 0; i < 260; i++) begin
      instr = {6'h3F, 26'($urandom)};
      rs_val = $urandom; rt_val = $urandom;
      cycle();
    end
    chk("sat_count", 32'(illegal_count), 255);
    chk("sat_illegal", 32'(illegal), 1);
    chk("sat_ctrl", 32'(control), 0);
    chk("sat_wr", 32'(reg_write), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
